// File: rtl/uart_tx_fifo_if.sv
// Bus-side bundle of the UART transmitter: write strobe/data in, FIFO flags and serial line out.
interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic                 wrEn;
   logic [DATA_BITS-1:0] wrData;
   logic                 full;
   logic                 empty;
   logic                 txSerial;
   logic                 busy;
   logic                 txDone;

   modport master (
      output wrEn, wrData,
      input  full, empty, txSerial, busy, txDone
   );

   modport slave (
      input  wrEn, wrData,
      output full, empty, txSerial, busy, txDone
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter (start, LSB-first data, optional even parity under UART_TX_PARITY_EN, stop bits).
// Head word pops straight into a start bit the edge after it lands; writes while full are dropped.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 86,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_fifo_if.slave bus
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int BAW = $clog2(CLKS_PER_BIT);
   localparam int BW  = $clog2(DATA_BITS + 1);
   localparam logic [BAW-1:0] BAUD_LAST = BAW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0]  DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0]  STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic [CW-1:0]  DEPTH     = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [BAW-1:0]       baud_q, baud_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   logic                 full, empty, push, pop, baud_last, busy, tx_done;
   logic [DATA_BITS-1:0] head;

   assign full      = (count_q == DEPTH);
   assign empty     = (count_q == '0);
   assign baud_last = (baud_q == BAUD_LAST);
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      push     = bus.wrEn && !full;
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.wrData;
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_last ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (!empty) pop = 1'b1;
         end
         S_START: begin
            if (baud_last) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  tx_d    = parity_q;
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
                  bit_d   = '0;
`endif
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_last) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
               bit_d   = '0;
            end
         end
`endif
         S_STOP: begin
            if (baud_last) begin
               if (bit_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
                  if (!empty) pop = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A pop from IDLE or from the last stop cycle both launch a start bit immediately.
      if (pop) begin
         state_d  = S_START;
         baud_d   = '0;
         bit_d    = '0;
         tx_d     = 1'b0;
         shift_d  = head;
`ifdef UART_TX_PARITY_EN
         parity_d = ^head;
`endif
      end
   end

   always_comb begin
      busy    = (state_q != S_IDLE);
      tx_done = (state_q == S_STOP) && baud_last && (bit_q == STOP_LAST);
   end

   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.txSerial = tx_q;
   assign bus.busy     = busy;
   assign bus.txDone   = tx_done;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: writes queue expected bytes, per-DUT monitors decode every serial frame cycle by cycle.
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   typedef struct packed {
      logic [8:0] data;
      logic       contig;
      logic       abort;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb [2][$];

   uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
   uart_tx_fifo_if #(.DATA_BITS(7)) if1 ();

   uart_tx_fifo #(.CLKS_PER_BIT(86), .DATA_BITS(8), .FIFO_DEPTH(4), .STOP_BITS(1)) dut0 (
      .clk (clk), .rst (rst), .bus (if0.slave)
   );
   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .FIFO_DEPTH(4), .STOP_BITS(2)) dut1 (
      .clk (clk), .rst (rst), .bus (if1.slave)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cpb_of(input int sel);   return (sel == 0) ? 86 : 4; endfunction
   function automatic int nb_of(input int sel);    return (sel == 0) ? 8 : 7;  endfunction
   function automatic int stop_of(input int sel);  return (sel == 0) ? 1 : 2;  endfunction
   function automatic int flen(input int sel);
      return (1 + nb_of(sel) + PB + stop_of(sel)) * cpb_of(sel);
   endfunction
   function automatic logic tx_of(input int sel);    return (sel == 0) ? if0.txSerial : if1.txSerial; endfunction
   function automatic logic done_of(input int sel);  return (sel == 0) ? if0.txDone : if1.txDone; endfunction
   function automatic logic busy_of(input int sel);  return (sel == 0) ? if0.busy : if1.busy; endfunction

   function automatic logic frame_bit(input int sel, input logic [8:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= nb_of(sel)) return d[idx-1];
      if (PB == 1 && idx == nb_of(sel) + 1) return ^d;
      return 1'b1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wr(input int sel, input logic [8:0] d, input bit accept, input bit contig, input bit abort);
      exp_t e;
      if (sel == 0) begin
         if0.wrEn = 1'b1; if0.wrData = d[7:0]; e.data = {1'b0, d[7:0]};
      end else begin
         if1.wrEn = 1'b1; if1.wrData = d[6:0]; e.data = {2'b0, d[6:0]};
      end
      e.contig = contig;
      e.abort  = abort;
      if (accept) sb[sel].push_back(e);
      @(negedge clk);
      if0.wrEn = 1'b0;
      if1.wrEn = 1'b0;
   endtask

   task automatic wait_idle(input int sel, input int budget);
      int n = 0;
      while ((sb[sel].size() != 0 || busy_of(sel)) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("idle_within_budget%0d", sel), int'(n < budget), 1);
   endtask

   task automatic mon(input int sel);
      exp_t e;
      int   t0, len, last_end;
      bit   bit_err, done_err, busy_err, aborted, done_seen;
      last_end = -1000;
      len = flen(sel);
      forever begin
         @(negedge clk);
         if (!rst && tx_of(sel) == 1'b0) begin
            t0 = cyc;
            bit_err = 0; done_err = 0; busy_err = 0; aborted = 0; done_seen = 0;
            if (sb[sel].size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_frame%0d: start bit at cycle %0d, none expected", sel, t0);
               e = '0;
            end else begin
               e = sb[sel].pop_front();
            end
            n_tests++;
            if ((t0 - last_end == 1) != e.contig) begin
               n_fail++;
               $display("FAIL contiguity%0d: gap %0d cycles, contiguous expected %0d", sel, t0 - last_end - 1, e.contig);
            end
            for (int c = 0; c < len; c++) begin
               if (c > 0) @(negedge clk);
               if (rst) begin
                  aborted = 1;
                  break;
               end
               if (tx_of(sel) != frame_bit(sel, e.data, c / cpb_of(sel))) bit_err = 1;
               if (done_of(sel)) done_seen = 1;
               if (done_of(sel) != (c == len - 1)) done_err = 1;
               if (!busy_of(sel)) busy_err = 1;
            end
            last_end = aborted ? -1000 : cyc;
            n_tests++;
            if (e.abort) begin
               if (!aborted || done_seen) begin
                  n_fail++;
                  $display("FAIL abort%0d data=%h: aborted=%0d txDone_seen=%0d, expected 1/0", sel, e.data, aborted, done_seen);
               end
            end else if (aborted || bit_err || done_err || busy_err) begin
               n_fail++;
               $display("FAIL frame%0d data=%h: aborted=%0d bit_err=%0d done_err=%0d busy_err=%0d, expected all 0",
                        sel, e.data, aborted, bit_err, done_err, busy_err);
            end
         end
      end
   endtask

   initial fork
      mon(0);
      mon(1);
   join_none

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      if0.wrEn = 1'b0; if0.wrData = '0;
      if1.wrEn = 1'b0; if1.wrData = '0;
      repeat (3) @(negedge clk);
      chk("rst_txSerial", if0.txSerial, 1);
      chk("rst_busy", if0.busy, 0);
      chk("rst_txDone", if0.txDone, 0);
      chk("rst_full", if0.full, 0);
      chk("rst_empty", if0.empty, 1);
      rst = 1'b0;
      @(negedge clk);

      // single frame 0xA5
      wr(0, 9'h0A5, 1, 0, 0);
      chk("wr_empty", if0.empty, 0);
      chk("wr_busy_before_pop", if0.busy, 0);
      @(negedge clk);
      chk("pop_busy", if0.busy, 1);
      chk("pop_empty", if0.empty, 1);
      chk("pop_txSerial", if0.txSerial, 0);
      wait_idle(0, flen(0) + 20);
      chk("after_txSerial", if0.txSerial, 1);
      chk("after_txDone", if0.txDone, 0);

      // burst of five, sixth dropped
      repeat (5) @(negedge clk);
      wr(0, 9'h011, 1, 0, 0);
      wr(0, 9'h022, 1, 1, 0);
      wr(0, 9'h033, 1, 1, 0);
      wr(0, 9'h044, 1, 1, 0);
      wr(0, 9'h055, 1, 1, 0);
      chk("burst_full", if0.full, 1);
      wr(0, 9'h066, 0, 0, 0);
      chk("drop_full", if0.full, 1);
      chk("drop_empty", if0.empty, 0);
      wait_idle(0, 6 * flen(0));

      // simultaneous write and pop keeps count at one
      repeat (5) @(negedge clk);
      wr(0, 9'h05A, 1, 0, 0);
      k = cyc;
      wr(0, 9'h0C3, 1, 1, 0);
      chk("simul_pop_empty", if0.empty, 0);
      while (cyc < k + flen(0)) @(negedge clk);
      chk("frame_end_txDone", if0.txDone, 1);
      wr(0, 9'h096, 1, 1, 0);
      chk("simul_end_empty", if0.empty, 0);
      chk("simul_end_full", if0.full, 0);
      chk("simul_end_busy", if0.busy, 1);
      wait_idle(0, 4 * flen(0));

      // reset during data bit 3
      repeat (5) @(negedge clk);
      wr(0, 9'h0E7, 1, 0, 1);
      @(negedge clk);
      repeat (86 * 4 + 40) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_txSerial", if0.txSerial, 1);
      chk("midrst_empty", if0.empty, 1);
      chk("midrst_busy", if0.busy, 0);
      chk("midrst_txDone", if0.txDone, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("postrst_busy", if0.busy, 0);
      wr(0, 9'h03C, 1, 0, 0);
      wait_idle(0, flen(0) + 20);

      // 7 data bits, 2 stop bits, 4 clocks per bit
      wr(1, 9'h041, 1, 0, 0);
      chk("p_wr_empty", if1.empty, 0);
      wait_idle(1, flen(1) + 20);
      chk("p_txSerial", if1.txSerial, 1);

      chk("sb0_drained", sb[0].size(), 0);
      chk("sb1_drained", sb[1].size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
